// File: rtl/div_radix2_seq.sv
// rtl/div_radix2_seq.sv - sequential radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU
module div_radix2_seq #(
    parameter int length = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable_div,
    input  logic [1:0]        operation,
    input  logic [length-1:0] dividend,
    input  logic [length-1:0] divisor,
    output logic [length-1:0] div_o,
    output logic              div_finish,
    output logic              div_busy
);

    localparam int CW = (length > 1) ? $clog2(length) : 1;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_ITER = 2'b01;
    localparam logic [1:0] ST_FIX  = 2'b10;

    localparam logic [length-1:0] ALL_ONES = {length{1'b1}};
    localparam logic [length-1:0] MIN_NEG  = {1'b1, {(length-1){1'b0}}};

    logic [1:0]        state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [length:0]   r_q, r_d;
    logic [length-1:0] q_q, q_d;
    logic [length-1:0] dvs_q, dvs_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              neg_q_q, neg_q_d;
    logic              neg_r_q, neg_r_d;
    logic              special_q, special_d;
    logic [length-1:0] div_o_q, div_o_d;
    logic              finish_q, finish_d;

    logic              is_signed;
    logic [length-1:0] a_mag, b_mag;
    logic [length:0]   r_sh, trial;
    logic [length-1:0] q_sh, fix_sel;
    logic              fix_neg;

    // bit 0 of operation distinguishes unsigned (1) from signed (0) ops
    assign is_signed = ~operation[0];
    assign a_mag = (is_signed && dividend[length-1]) ? -dividend : dividend;
    assign b_mag = (is_signed && divisor[length-1])  ? -divisor  : divisor;

    assign r_sh  = {r_q[length-1:0], q_q[length-1]};
    assign q_sh  = {q_q[length-2:0], 1'b0};
    assign trial = r_sh - {1'b0, dvs_q};

    assign fix_sel = op_q[1] ? r_q[length-1:0] : q_q;
    assign fix_neg = ~special_q & (op_q[1] ? neg_r_q : neg_q_q);

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        r_d       = r_q;
        q_d       = q_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        neg_q_d   = neg_q_q;
        neg_r_d   = neg_r_q;
        special_d = special_q;
        div_o_d   = div_o_q;
        finish_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable_div) begin
                    op_d      = operation;
                    dvs_d     = b_mag;
                    neg_q_d   = is_signed & (dividend[length-1] ^ divisor[length-1]);
                    neg_r_d   = is_signed & dividend[length-1];
                    cnt_d     = CW'(length - 1);
                    special_d = 1'b0;
                    r_d       = '0;
                    q_d       = a_mag;
                    state_d   = ST_ITER;
                    // special cases preload Q/R with the final answers and skip iteration
                    if (divisor == '0) begin
                        special_d = 1'b1;
                        q_d       = ALL_ONES;
                        r_d       = {1'b0, dividend};
                        state_d   = ST_FIX;
                    end else if (is_signed && dividend == MIN_NEG && divisor == ALL_ONES) begin
                        special_d = 1'b1;
                        q_d       = dividend;
                        r_d       = '0;
                        state_d   = ST_FIX;
                    end
                end
            end
            ST_ITER: begin
                if (!trial[length]) begin
                    r_d = trial;
                    q_d = {q_sh[length-1:1], 1'b1};
                end else begin
                    r_d = r_sh;
                    q_d = q_sh;
                end
                if (cnt_q == '0) begin
                    state_d = ST_FIX;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_FIX: begin
                div_o_d  = fix_neg ? -fix_sel : fix_sel;
                finish_d = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            r_q       <= '0;
            q_q       <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            neg_q_q   <= 1'b0;
            neg_r_q   <= 1'b0;
            special_q <= 1'b0;
            div_o_q   <= '0;
            finish_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            r_q       <= r_d;
            q_q       <= q_d;
            dvs_q     <= dvs_d;
            cnt_q     <= cnt_d;
            neg_q_q   <= neg_q_d;
            neg_r_q   <= neg_r_d;
            special_q <= special_d;
            div_o_q   <= div_o_d;
            finish_q  <= finish_d;
        end
    end

    assign div_o      = div_o_q;
    assign div_finish = finish_q;
    assign div_busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_div_radix2_seq.sv
// tb/tb_div_radix2_seq.sv - randomized self-checking bench for div_radix2_seq
module tb_div_radix2_seq;

    localparam int L = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         enable_div = 1'b0;
    logic [1:0]   operation = 2'b00;
    logic [L-1:0] dividend = '0;
    logic [L-1:0] divisor = '0;
    logic [L-1:0] div_o;
    logic         div_finish;
    logic         div_busy;

    int n_chk = 0;
    int n_pass = 0;

    div_radix2_seq #(.length(L)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable_div (enable_div),
        .operation  (operation),
        .dividend   (dividend),
        .divisor    (divisor),
        .div_o      (div_o),
        .div_finish (div_finish),
        .div_busy   (div_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // RISC-V M-extension semantics in plain integer arithmetic
    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int signed sa;
        int signed sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : a;
            return op[1] ? 32'(sa % sb) : 32'(sa / sb);
        end
        return op[1] ? a % b : a / b;
    endfunction

    function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return L + 1;
    endfunction

    // drives a start strobe and returns #1 after the accepting edge
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        operation  = op;
        dividend   = a;
        divisor    = b;
        enable_div = 1'b1;
        @(posedge clk);
        #1;
        enable_div = 1'b0;
        operation  = $urandom_range(0, 3);
        dividend   = $urandom;
        divisor    = $urandom;
    endtask

    // counts edges after accept until div_finish; optional busy-time poke and hold check
    task automatic wait_finish(output int lat, input bit poke, input bit chk_hold, input logic [31:0] hold_val);
        lat = -1;
        for (int m = 1; m <= 100; m++) begin
            if (poke && m == 5) begin
                operation  = 2'b00;
                dividend   = 32'd100;
                divisor    = 32'd7;
                enable_div = 1'b1;
            end
            @(posedge clk);
            #1;
            if (poke && m == 5) enable_div = 1'b0;
            if (div_finish) begin
                lat = m;
                break;
            end
            if (chk_hold) check("hold_prev_result", div_o, hold_val);
        end
        if (lat < 0) check("finish_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
        int lat;
        issue(op, a, b);
        check({tag, "_busy"}, 32'(div_busy), 32'd1);
        wait_finish(lat, 1'b0, 1'b0, '0);
        check({tag, "_lat"}, 32'(lat), 32'(ref_lat(op, a, b)));
        check({tag, "_res"}, div_o, ref_div(op, a, b));
        check({tag, "_idle"}, 32'(div_busy), 32'd0);
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, 32'(div_finish), 32'd0);
    endtask

    initial begin
        int lat;
        bit seen;
        logic [1:0]  op;
        logic [31:0] a, b;

        repeat (3) @(posedge clk);
        #1;
        check("rst_div_o", div_o, 32'd0);
        check("rst_finish", 32'(div_finish), 32'd0);
        check("rst_busy", 32'(div_busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op(2'b00, 32'd100, 32'd7, "div_100_7");
        run_op(2'b10, 32'd100, 32'd7, "rem_100_7");
        run_op(2'b00, -32'd7, 32'd2, "div_m7_2");
        run_op(2'b10, -32'd7, 32'd2, "rem_m7_2");
        run_op(2'b10, 32'd7, -32'd2, "rem_7_m2");
        run_op(2'b01, 32'hFFFF_FFFF, 32'd2, "divu_max_2");
        run_op(2'b11, 32'hFFFF_FFFF, 32'd2, "remu_max_2");
        run_op(2'b00, 32'd5, 32'd0, "div_by0");
        run_op(2'b11, 32'h1234, 32'd0, "remu_by0");
        run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");

        // reset mid-operation
        issue(2'b00, 32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_div_o", div_o, 32'd0);
        check("abort_busy", 32'(div_busy), 32'd0);
        seen = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            seen |= div_finish;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1;
            seen |= div_finish | div_busy;
        end
        check("abort_no_finish", 32'(seen), 32'd0);
        run_op(2'b00, 32'd1000, 32'd3, "div_after_rst");

        // start ignored while busy, then back-to-back start in the finish cycle
        issue(2'b01, 32'd50, 32'd5);
        wait_finish(lat, 1'b1, 1'b0, '0);
        check("b2b_first_lat", 32'(lat), 32'd33);
        check("b2b_first_res", div_o, 32'd10);
        issue(2'b11, 32'd50, 32'd6);
        check("b2b_busy", 32'(div_busy), 32'd1);
        wait_finish(lat, 1'b0, 1'b1, 32'd10);
        check("b2b_second_lat", 32'(lat), 32'd33);
        check("b2b_second_res", div_o, 32'd2);
        @(posedge clk);
        #1;

        for (int i = 0; i < 60; i++) begin
            op = 2'($urandom_range(0, 3));
            a = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3: b = 32'hFFFF_FFFF;
                4: b = -32'($urandom_range(1, 300));
                5: begin a = 32'($urandom_range(0, 20)); b = $urandom; end
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            run_op(op, a, b, $sformatf("rnd%0d_op%0d", i, op));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
